// File: rtl/e203_ifu_litebpu_seq_pkg.sv
// e203_ifu_litebpu_seq_pkg: FSM state encodings and register index constants for the lite BPU
package e203_ifu_litebpu_seq_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_USE  = 2'd2;
  localparam logic [4:0] X0 = 5'd0;
  localparam logic [4:0] X1 = 5'd1;
  localparam logic [4:0] X5 = 5'd5;
  function automatic logic is_link(input logic [4:0] idx);
    return (idx == X1) | (idx == X5);
  endfunction
endpackage

// File: rtl/e203_ifu_litebpu_seq_if.sv
// e203_ifu_litebpu_seq_if: mini-decoder, IR/OITF status, regfile and prediction signals of the lite BPU
interface e203_ifu_litebpu_seq_if #(
  parameter int PC_W   = 32,
  parameter int XLEN_W = 32
);
  logic [PC_W-1:0]   pc;
  logic              dec_i_valid;
  logic              dec_accept;
  logic              dec_jal;
  logic              dec_jalr;
  logic              dec_bxx;
  logic [XLEN_W-1:0] dec_bjp_imm;
  logic [4:0]        dec_jalr_rs1idx;
  logic [4:0]        dec_rdidx;
  logic              oitf_empty;
  logic              ir_empty;
  logic              ir_valid_clr;
  logic              ir_rd_is_x1;
  logic              flush;
  logic [XLEN_W-1:0] rf2bpu_x1;
  logic [XLEN_W-1:0] rf2bpu_rs1;
  logic              prdt_taken;
  logic [PC_W-1:0]   prdt_pc_add_op1;
  logic [PC_W-1:0]   prdt_pc_add_op2;
  logic              bpu_wait;
  logic              bpu2rf_rs1_ena;
  modport master (
    output pc, dec_i_valid, dec_accept, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm,
           dec_jalr_rs1idx, dec_rdidx, oitf_empty, ir_empty, ir_valid_clr, ir_rd_is_x1,
           flush, rf2bpu_x1, rf2bpu_rs1,
    input  prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2, bpu_wait, bpu2rf_rs1_ena
  );
  modport slave (
    input  pc, dec_i_valid, dec_accept, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm,
           dec_jalr_rs1idx, dec_rdidx, oitf_empty, ir_empty, ir_valid_clr, ir_rd_is_x1,
           flush, rf2bpu_x1, rf2bpu_rs1,
    output prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2, bpu_wait, bpu2rf_rs1_ena
  );
endinterface

// File: rtl/e203_ifu_litebpu_seq_ras.sv
// e203_ifu_ras: return address stack; wraps over the oldest entry when full, push+pop replaces the top
module e203_ifu_ras #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   ptr;
  logic [AW:0]     cnt;
  logic [AW-1:0]   top_idx;
  assign top_idx = ptr - AW'(1);
  assign top     = mem[top_idx];
  assign empty   = (cnt == '0);
  // pointer to the next free slot and saturating occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push & ~pop) begin
      ptr <= ptr + AW'(1);
      cnt <= (cnt == FULL) ? cnt : cnt + (AW+1)'(1);
    end else if (pop & ~push) begin
      ptr <= top_idx;
      cnt <= cnt - (AW+1)'(1);
    end
  end
  // entry storage; a simultaneous pop turns the push into a top overwrite
  always_ff @(posedge clk) begin
    if (push) mem[pop ? top_idx : ptr] <= push_data;
  end
endmodule

// File: rtl/e203_ifu_litebpu_seq.sv
// e203_ifu_litebpu_seq: static branch predictor with jalr rs1 hazard FSM; optional RAS under E203_CFG_IFU_RAS_EN
module e203_ifu_litebpu_seq
  import e203_ifu_litebpu_seq_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int XLEN_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  e203_ifu_litebpu_seq_if.slave bpu
);
  logic [1:0]      state, state_nxt;
  logic            valid, rs1_x0, rs1_x1, jalr_x1, jalr_xn, dep, rs1_ena;
  logic            ras_hit;
  logic [PC_W-1:0] ras_top;
  assign valid   = bpu.dec_i_valid;
  assign rs1_x0  = (bpu.dec_jalr_rs1idx == X0);
  assign rs1_x1  = (bpu.dec_jalr_rs1idx == X1);
  assign jalr_x1 = valid & bpu.dec_jalr & rs1_x1 & ~ras_hit;
  assign jalr_xn = valid & bpu.dec_jalr & ~rs1_x0 & ~rs1_x1 & ~ras_hit;
  assign dep     = ~bpu.oitf_empty | (~bpu.ir_empty & ~bpu.ir_valid_clr);
  assign rs1_ena = jalr_xn & ~dep & ~bpu.flush & (state != ST_USE);
`ifdef E203_CFG_IFU_RAS_EN
  logic rd_link, rs1_link, ras_empty;
  assign rd_link  = is_link(bpu.dec_rdidx);
  assign rs1_link = is_link(bpu.dec_jalr_rs1idx);
  assign ras_hit  = valid & bpu.dec_jalr & rs1_link & ~ras_empty
                  & ((bpu.dec_rdidx == X0) | (rd_link & (bpu.dec_rdidx != bpu.dec_jalr_rs1idx)));
  e203_ifu_ras #(.DEPTH(RAS_DEPTH), .PC_W(PC_W)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (valid & bpu.dec_accept & (bpu.dec_jal | bpu.dec_jalr) & rd_link),
    .pop       (bpu.dec_accept & ras_hit),
    .push_data (bpu.pc + PC_W'(4)),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  assign ras_hit = 1'b0;
  assign ras_top = '0;
`endif
  // prediction outputs, all forced low without a valid decoded instruction
  always_comb begin
    bpu.prdt_taken      = valid & (bpu.dec_jal | bpu.dec_jalr | (bpu.dec_bxx & bpu.dec_bjp_imm[XLEN_W-1]));
    bpu.prdt_pc_add_op1 = ~valid ? '0 : ras_hit ? ras_top : ~bpu.dec_jalr ? bpu.pc
                        : rs1_x0 ? '0 : rs1_x1 ? PC_W'(bpu.rf2bpu_x1) : PC_W'(bpu.rf2bpu_rs1);
    bpu.prdt_pc_add_op2 = (~valid | ras_hit | ~(bpu.dec_jal | bpu.dec_jalr | bpu.dec_bxx)) ? '0
                        : PC_W'(bpu.dec_bjp_imm);
    bpu.bpu_wait        = (jalr_x1 & (~bpu.oitf_empty | (~bpu.ir_empty & bpu.ir_rd_is_x1)))
                        | (jalr_xn & (state != ST_USE));
    bpu.bpu2rf_rs1_ena  = rs1_ena;
  end
  // next state: flush wins, a read request moves to USE, a hazarded jalr parks in WAIT
  always_comb begin
    state_nxt = bpu.flush ? ST_IDLE
              : rs1_ena ? ST_USE
              : ((state == ST_IDLE) & jalr_xn) ? ST_WAIT
              : ((state == ST_USE) & bpu.dec_accept) ? ST_IDLE
              : state;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  end
endmodule

// File: tb/tb_e203_ifu_litebpu_seq.sv
// tb_e203_ifu_litebpu_seq: directed vectors with a behavioural prediction model checked every cycle
module tb_e203_ifu_litebpu_seq;
`ifdef E203_CFG_IFU_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int RAS_D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  e203_ifu_litebpu_seq_if #(.PC_W(32), .XLEN_W(32)) bif ();
  e203_ifu_litebpu_seq #(.PC_W(32), .XLEN_W(32), .RAS_DEPTH(RAS_D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bpu   (bif)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // model: "fetched" means the jalr base register has already been read for the current instruction
  bit          fetched = 1'b0;
  logic [31:0] ras_q[$];
  bit          m_hit, m_xn, m_x1, m_dep, e_taken, e_wait, e_ena;
  logic [31:0] e_op1, e_op2;

  always @(negedge clk) begin
    if (!rst_n) begin
      fetched = 1'b0;
      ras_q.delete();
    end
    m_hit = RAS_EN && bif.dec_i_valid && bif.dec_jalr && link(bif.dec_jalr_rs1idx) && (ras_q.size() > 0)
            && ((bif.dec_rdidx == 5'd0) || (link(bif.dec_rdidx) && (bif.dec_rdidx != bif.dec_jalr_rs1idx)));
    m_x1  = bif.dec_i_valid && bif.dec_jalr && !m_hit && (bif.dec_jalr_rs1idx == 5'd1);
    m_xn  = bif.dec_i_valid && bif.dec_jalr && !m_hit && (bif.dec_jalr_rs1idx > 5'd1);
    m_dep = !bif.oitf_empty || (!bif.ir_empty && !bif.ir_valid_clr);
    e_taken = bif.dec_i_valid && (bif.dec_jal || bif.dec_jalr || (bif.dec_bxx && bif.dec_bjp_imm[31]));
    if (!bif.dec_i_valid) e_op1 = 0;
    else if (m_hit) e_op1 = ras_q[$];
    else if (!bif.dec_jalr) e_op1 = bif.pc;
    else if (bif.dec_jalr_rs1idx == 5'd0) e_op1 = 0;
    else if (bif.dec_jalr_rs1idx == 5'd1) e_op1 = bif.rf2bpu_x1;
    else e_op1 = bif.rf2bpu_rs1;
    e_op2 = (bif.dec_i_valid && !m_hit && (bif.dec_jal || bif.dec_jalr || bif.dec_bxx)) ? bif.dec_bjp_imm : 0;
    e_wait = (m_x1 && (!bif.oitf_empty || (!bif.ir_empty && bif.ir_rd_is_x1))) || (m_xn && !fetched);
    e_ena  = m_xn && !fetched && !m_dep && !bif.flush;
    chk("taken", {31'd0, bif.prdt_taken}, {31'd0, e_taken});
    chk("op1", bif.prdt_pc_add_op1, e_op1);
    chk("op2", bif.prdt_pc_add_op2, e_op2);
    chk("wait", {31'd0, bif.bpu_wait}, {31'd0, e_wait});
    chk("rs1_ena", {31'd0, bif.bpu2rf_rs1_ena}, {31'd0, e_ena});
    if (rst_n) begin
      if (bif.flush) fetched = 1'b0;
      else if (e_ena) fetched = 1'b1;
      else if (bif.dec_accept) fetched = 1'b0;
      if (RAS_EN && bif.dec_i_valid && bif.dec_accept) begin
        if (m_hit) void'(ras_q.pop_back());
        if ((bif.dec_jal || bif.dec_jalr) && link(bif.dec_rdidx)) begin
          ras_q.push_back(bif.pc + 32'd4);
          if (ras_q.size() > RAS_D) void'(ras_q.pop_front());
        end
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic v, jal, jalr, bxx, input logic [31:0] p, imm,
                         input logic [4:0] rs1, rd, input logic acc);
    bif.dec_i_valid = v;
    bif.dec_jal = jal;
    bif.dec_jalr = jalr;
    bif.dec_bxx = bxx;
    bif.pc = p;
    bif.dec_bjp_imm = imm;
    bif.dec_jalr_rs1idx = rs1;
    bif.dec_rdidx = rd;
    bif.dec_accept = acc;
  endtask

  task automatic quiet;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bif.oitf_empty = 1;
    bif.ir_empty = 1;
    bif.ir_valid_clr = 0;
    bif.ir_rd_is_x1 = 0;
    bif.flush = 0;
    bif.rf2bpu_x1 = 0;
    bif.rf2bpu_rs1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ret_exp [5];
    quiet();
    repeat (2) @(negedge clk);
    chk("rst_taken", {31'd0, bif.prdt_taken}, 32'd0);
    chk("rst_wait", {31'd0, bif.bpu_wait}, 32'd0);
    nxt();
    rst_n = 1;
    nxt();
    set_ins(1, 1, 0, 0, 32'h100, 32'h40, 0, 0, 1);
    @(negedge clk);
    chk("jal_taken", {31'd0, bif.prdt_taken}, 32'd1);
    chk("jal_op1", bif.prdt_pc_add_op1, 32'h100);
    chk("jal_op2", bif.prdt_pc_add_op2, 32'h40);
    chk("jal_wait", {31'd0, bif.bpu_wait}, 32'd0);
    nxt();
    set_ins(1, 0, 0, 1, 32'h104, 32'hFFFF_FFF0, 0, 0, 1);
    @(negedge clk);
    chk("bxx_back_taken", {31'd0, bif.prdt_taken}, 32'd1);
    chk("bxx_back_op2", bif.prdt_pc_add_op2, 32'hFFFF_FFF0);
    nxt();
    set_ins(1, 0, 0, 1, 32'h108, 32'h10, 0, 0, 1);
    @(negedge clk);
    chk("bxx_fwd_taken", {31'd0, bif.prdt_taken}, 32'd0);
    chk("bxx_fwd_op1", bif.prdt_pc_add_op1, 32'h108);
    nxt();
    set_ins(1, 0, 0, 0, 32'h10C, 32'h55, 0, 0, 1);
    @(negedge clk);
    chk("plain_op2", bif.prdt_pc_add_op2, 32'h0);
    nxt();
    set_ins(1, 0, 1, 0, 32'h110, 32'h80, 0, 0, 1);
    @(negedge clk);
    chk("jalr_x0_op1", bif.prdt_pc_add_op1, 32'h0);
    chk("jalr_x0_op2", bif.prdt_pc_add_op2, 32'h80);
    nxt();
    // jalr x5 hazarded by OITF for three cycles, held one cycle in USE before accept
    set_ins(1, 0, 1, 0, 32'h114, 32'h8, 5, 0, 0);
    bif.rf2bpu_rs1 = 32'h2000;
    bif.oitf_empty = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) bif.oitf_empty = 1;
      if (i == 6) bif.dec_accept = 1;
      @(negedge clk);
      chk($sformatf("x5_wait_c%0d", i), {31'd0, bif.bpu_wait}, (i <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("x5_ena_c%0d", i), {31'd0, bif.bpu2rf_rs1_ena}, (i == 4) ? 32'd1 : 32'd0);
      if (i == 5) chk("x5_op1", bif.prdt_pc_add_op1, 32'h2000);
      nxt();
    end
    quiet();
    nxt();
    // jalr x1 while the IR holds an x1 writer
    set_ins(1, 0, 1, 0, 32'h118, 32'h4, 1, 0, 0);
    bif.rf2bpu_x1 = 32'h3000;
    bif.ir_empty = 0;
    bif.ir_rd_is_x1 = 1;
    repeat (2) begin
      @(negedge clk);
      chk("x1_wait_hz", {31'd0, bif.bpu_wait}, 32'd1);
      nxt();
    end
    bif.ir_empty = 1;
    bif.dec_accept = 1;
    @(negedge clk);
    chk("x1_wait_clr", {31'd0, bif.bpu_wait}, 32'd0);
    chk("x1_op1", bif.prdt_pc_add_op1, 32'h3000);
    nxt();
    quiet();
    // flush while parked in WAIT, with the hazard clearing in the same cycle
    set_ins(1, 0, 1, 0, 32'h11C, 32'h0, 7, 0, 0);
    bif.rf2bpu_rs1 = 32'h4000;
    bif.oitf_empty = 0;
    nxt();
    bif.flush = 1;
    bif.oitf_empty = 1;
    @(negedge clk);
    chk("flush_ena", {31'd0, bif.bpu2rf_rs1_ena}, 32'd0);
    nxt();
    bif.flush = 0;
    bif.dec_i_valid = 0;
    @(negedge clk);
    chk("post_flush_wait", {31'd0, bif.bpu_wait}, 32'd0);
    nxt();
    bif.dec_i_valid = 1;
    @(negedge clk);
    chk("refetch_ena", {31'd0, bif.bpu2rf_rs1_ena}, 32'd1);
    nxt();
    bif.dec_accept = 1;
    @(negedge clk);
    chk("refetch_op1", bif.prdt_pc_add_op1, 32'h4000);
    nxt();
    quiet();
    // IR draining this cycle does not count as a hazard
    set_ins(1, 0, 1, 0, 32'h120, 32'h0, 6, 0, 0);
    bif.ir_empty = 0;
    bif.ir_valid_clr = 1;
    @(negedge clk);
    chk("irclr_ena", {31'd0, bif.bpu2rf_rs1_ena}, 32'd1);
    nxt();
    bif.dec_accept = 1;
    @(negedge clk);
    chk("irclr_wait", {31'd0, bif.bpu_wait}, 32'd0);
    nxt();
    quiet();
    nxt();
    if (RAS_EN) begin
      ret_exp[0] = 32'h1044;
      ret_exp[1] = 32'h1034;
      ret_exp[2] = 32'h1024;
      ret_exp[3] = 32'h1014;
      ret_exp[4] = 32'hDEAD_0000;
      for (int i = 0; i < 5; i++) begin
        set_ins(1, 1, 0, 0, 32'h1000 + 32'(i) * 32'h10, 32'h100, 0, 1, 1);
        nxt();
      end
      bif.rf2bpu_x1 = 32'hDEAD_0000;
      for (int i = 0; i < 5; i++) begin
        set_ins(1, 0, 1, 0, 32'h2000 + 32'(i) * 32'h4, 32'h0, 1, 0, 1);
        @(negedge clk);
        chk($sformatf("ret%0d_op1", i), bif.prdt_pc_add_op1, ret_exp[i]);
        chk($sformatf("ret%0d_wait", i), {31'd0, bif.bpu_wait}, 32'd0);
        nxt();
      end
      quiet();
    end
    repeat (2) nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
